// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM encoding and default limits for the memory arbiter
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int STARVE_MAX_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT    = 16;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of a single-port memory
// with starvation guard for fetch and a bounded wait on mem_ack.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [SW-1:0] starveCnt;
  logic [WW-1:0] waitCnt;
  logic          dataWins;
  logic          accessEnds;

  assign dataWins   = d_req && (!if_req || (starveCnt < SW'(STARVE_MAX)));
  // waitCnt holds the BUSY cycles already spent, so this is the TIMEOUT-th one
  assign accessEnds = mem_ack || (waitCnt == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      starveCnt <= '0;
      waitCnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      err       <= 1'b0;
    end else begin
      if (!if_req) begin
        starveCnt <= '0;
      end
      case (state)
        IDLE: begin
          waitCnt <= '0;
          if (dataWins) begin
            state     <= BUSY_D;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (if_req && (starveCnt < SW'(STARVE_MAX))) begin
              starveCnt <= starveCnt + 1'b1;
            end
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            starveCnt <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (accessEnds) begin
            state  <= DONE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (!mem_ack) begin
              err <= 1'b1;
            end
            if (state == BUSY_I) begin
              if_ready <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_MAX(SMAX),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .err(err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] memory [bit [31:0]];
  req_t        fetchQ[$];
  req_t        dataQ[$];
  logic [31:0] logAddr[$];
  logic        logWe[$];
  logic        prevMemEn = 1'b0;

  bit          fActive = 0, dActive = 0, fDropEarly = 0;
  int          fPresent, dPresent, fLat, dLat;
  logic [31:0] fData, dData;

  int ackDelay  = 1;
  int busyCycle = 0;
  bit strayAck  = 0;

  // model: one access in flight at most, a completion slot, and a tally of fetch losses
  bit          mInFlight = 0, mIsData = 0, mGWe = 0;
  logic [31:0] mGAddr = 0, mGWdata = 0;
  int          mBusy = 0;
  bit          mComplete = 0, mCompData = 0;
  logic [31:0] mResult = 0;
  bit          mErr = 0;
  int          mStarve = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memory.exists(a)) return memory[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic compareOutputs();
    check("mem_en", {31'd0, mem_en}, {31'd0, mInFlight});
    check("if_ready", {31'd0, if_ready}, {31'd0, mComplete && !mCompData});
    check("d_ready", {31'd0, d_ready}, {31'd0, mComplete && mCompData});
    check("err", {31'd0, err}, {31'd0, mErr});
    if (mInFlight) begin
      check("mem_addr", mem_addr, mGAddr);
      check("mem_we", {31'd0, mem_we}, {31'd0, mGWe});
      if (mGWe) check("mem_wdata", mem_wdata, mGWdata);
    end
    if (mComplete && !mCompData) check("if_rdata", if_rdata, mResult);
    if (mComplete && mCompData) check("d_rdata", d_rdata, mResult);
  endtask

  task automatic driveStimulus();
    req_t r;
    if (mem_en && !prevMemEn) begin
      logAddr.push_back(mem_addr);
      logWe.push_back(mem_we);
    end
    prevMemEn = mem_en;
    if (mem_en) begin
      busyCycle++;
      mem_ack = (ackDelay > 0) && (busyCycle == ackDelay);
    end else begin
      busyCycle = 0;
      mem_ack   = strayAck;
    end
    mem_rdata = mem_ack ? memRead(mem_addr) : $urandom;
    if (mem_ack && mem_en && mem_we) memory[mem_addr] = mem_wdata;

    if (fActive && if_ready) begin
      fActive = 0; fLat = cyc - fPresent; fData = if_rdata; if_req = 1'b0;
    end else if (fActive && fDropEarly && cyc == fPresent + 1) begin
      if_req = 1'b0;
    end
    if (!fActive && fetchQ.size() > 0) begin
      r = fetchQ.pop_front();
      if_req = 1'b1; if_addr = r.addr; fActive = 1; fPresent = cyc;
    end

    if (dActive && d_ready) begin
      dActive = 0; dLat = cyc - dPresent; dData = d_rdata; d_req = 1'b0;
    end
    if (!dActive && dataQ.size() > 0) begin
      r = dataQ.pop_front();
      d_req = 1'b1; d_addr = r.addr; d_we = r.we; d_wdata = r.wdata;
      dActive = 1; dPresent = cyc;
    end
  endtask

  task automatic finishAccess(input logic [31:0] v);
    mInFlight = 0; mComplete = 1; mCompData = mIsData; mResult = v;
  endtask

  task automatic predict();
    if (reset) begin
      mInFlight = 0; mComplete = 0; mErr = 0; mStarve = 0; mBusy = 0;
      mGAddr = 0; mGWdata = 0; mGWe = 0;
      return;
    end
    if (!if_req) mStarve = 0;
    if (mComplete) begin
      mComplete = 0;
    end else if (mInFlight) begin
      mBusy++;
      if (mem_ack) finishAccess((mIsData && mGWe) ? 32'd0 : mem_rdata);
      else if (mBusy == TMO) begin
        finishAccess(32'd0);
        mErr = 1;
      end
    end else if (d_req && (!if_req || mStarve < SMAX)) begin
      mInFlight = 1; mIsData = 1; mBusy = 0;
      mGAddr = d_addr; mGWe = d_we; mGWdata = d_wdata;
      if (if_req && mStarve < SMAX) mStarve++;
    end else if (if_req) begin
      mInFlight = 1; mIsData = 0; mBusy = 0;
      mGAddr = if_addr; mGWe = 0; mGWdata = 0;
      mStarve = 0;
    end
  endtask

  task automatic step();
    compareOutputs();
    driveStimulus();
    predict();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic bit quiet();
    return !fActive && !dActive && fetchQ.size() == 0 && dataQ.size() == 0
           && !mInFlight && !mComplete;
  endfunction

  task automatic runUntilQuiet(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!quiet() && n < budget);
    check({"quiet_", name}, {31'd0, quiet()}, 32'd1);
  endtask

  initial begin
    int s;
    int readyCnt;
    reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    predict();
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    step();
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    step();

    // minimum-latency fetch
    memory[32'h100] = 32'hE3A0_1005;
    ackDelay = 1;
    s = logAddr.size();
    fetchQ.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    runUntilQuiet("fetch", 20);
    check("fetch_latency", fLat, 2);
    check("fetch_rdata", fData, 32'hE3A0_1005);
    check("fetch_addr_seen", logAddr[s], 32'h100);
    check("fetch_we_seen", {31'd0, logWe[s]}, 32'd0);

    // simultaneous requests: data write first, then fetch
    memory[32'h104] = 32'h1111_2222;
    s = logAddr.size();
    fetchQ.push_back('{addr: 32'h104, we: 1'b0, wdata: 32'h0});
    dataQ.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'hDEAD_BEEF});
    runUntilQuiet("both", 30);
    check("first_grant_addr", logAddr[s], 32'h200);
    check("first_grant_we", {31'd0, logWe[s]}, 32'd1);
    check("second_grant_addr", logAddr[s+1], 32'h104);
    check("mem_written", memory[32'h200], 32'hDEAD_BEEF);
    check("write_rdata", dData, 32'h0);
    check("fetch_after_data_lat", fLat, 5);
    check("fetch_after_data_rdata", fData, 32'h1111_2222);

    // starvation guard
    s = logAddr.size();
    fetchQ.push_back('{addr: 32'h108, we: 1'b0, wdata: 32'h0});
    for (int i = 0; i < 6; i++) dataQ.push_back('{addr: 32'h300 + 4 * i, we: 1'b0, wdata: 32'h0});
    runUntilQuiet("starve", 100);
    for (int i = 0; i < 4; i++) check("starve_data_grant", logAddr[s+i], 32'h300 + 4 * i);
    check("starve_fetch_grant", logAddr[s+4], 32'h108);
    check("starve_resume_data", logAddr[s+5], 32'h310);

    // ack on the last permitted BUSY cycle still completes normally
    memory[32'h404] = 32'hCAFE_F00D;
    ackDelay = TMO;
    dataQ.push_back('{addr: 32'h404, we: 1'b0, wdata: 32'h0});
    runUntilQuiet("late_ack", 40);
    check("late_ack_lat", dLat, 17);
    check("late_ack_rdata", dData, 32'hCAFE_F00D);
    check("late_ack_err", {31'd0, err}, 32'd0);

    // timeout
    ackDelay = 0;
    dataQ.push_back('{addr: 32'h400, we: 1'b0, wdata: 32'h0});
    runUntilQuiet("timeout", 40);
    check("timeout_lat", dLat, 17);
    check("timeout_rdata", dData, 32'h0);
    for (int i = 0; i < 5; i++) step();
    check("err_sticky", {31'd0, err}, 32'd1);

    // fetch requester drops req mid-access
    ackDelay = 3;
    fDropEarly = 1;
    fetchQ.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0});
    runUntilQuiet("drop", 20);
    fDropEarly = 0;
    check("drop_lat", fLat, 4);
    check("drop_rdata", fData, 32'hE3A0_1005);

    // reset mid data access
    ackDelay = 0;
    dataQ.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0});
    for (int i = 0; i < 3; i++) step();
    check("busy_before_reset", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    dActive = 0; d_req = 1'b0;
    step();
    reset = 1'b0;
    strayAck = 1;
    check("reset_mem_en", {31'd0, mem_en}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    s = logAddr.size();
    readyCnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (d_ready) readyCnt++;
    end
    strayAck = 0;
    check("no_ready_after_reset", readyCnt, 0);
    check("no_grant_after_reset", logAddr.size(), s);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
